axi4lite_mem_arbiter: RTL and testbench
=======================================

# axi4lite_mem_arbiter

Two-master, one-slave AXI4-Lite arbiter that lets the BottleRocket core's iBus and dBus share a single memory port, such as one unified `MockAXI4LiteSRAM` instead of separate imem/dmem instances. It grants one whole transaction at a time, read or write, in round-robin order. It forwards the granted master's channels to the slave and returns the response only to that master.

## Interface

Parameters:
- `ADDR_W`, default 32: address width on all ports.
- `DATA_W`, default 32: data width; strobe width is `DATA_W/8`.

Ports (N ∈ {0,1}; in0 = iBus, in1 = dBus):
- `clock`  in  1  sole clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_inN_aw_valid`/`_ready`/`_bits_addr`/`_bits_prot`/`_bits_cache`  in/out/in/in/in  1/1/ADDR_W/3/4  master N write address.
- `io_inN_w_valid`/`_ready`/`_bits_data`/`_bits_strb`  in/out/in/in  1/1/DATA_W/DATA_W/8  master N write data.
- `io_inN_b_valid`/`_ready`/`_bits_resp`  out/in/out  1/1/2  master N write response.
- `io_inN_ar_valid`/`_ready`/`_bits_addr`/`_bits_prot`/`_bits_cache`  in/out/in/in/in  1/1/ADDR_W/3/4  master N read address.
- `io_inN_r_valid`/`_ready`/`_bits_resp`/`_bits_data`  out/in/out/out  1/1/2/DATA_W  master N read data.
- `io_out_*`: the same five channels with directions mirrored, toward the slave.
- `io_owner`  out  1  index of the currently granted master.
- `io_busy`  out  1  high in every state except IDLE.

## Operation

- **States:** IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
- **Request definition:** master N requests when `aw_valid && w_valid` (write request) or `ar_valid` (read request).
- **IDLE arbitration:**
  - If both masters request, grant the master not granted last. The last-grant register resets to 0, so in1 (dBus) wins the first tie.
  - Within the granted master, a write request beats a read request.
  - Register `owner` and move to WR_ADDR or RD_ADDR.
  - No channel is forwarded while in IDLE.
- **WR_ADDR:**
  - `out_aw` = owner `aw` and `out_w` = owner `w`, combinational pass-through with `ready` routed back.
  - AW and W may complete in different cycles; sticky flags `aw_done` and `w_done` suppress re-issue of the finished channel.
  - Go to WR_RESP in the cycle both flags are set, counting a handshake that completes in that same cycle.
- **WR_RESP:** `out_b` is forwarded to the owner; on the `b` handshake go to IDLE.
- **RD_ADDR:** `out_ar` = owner `ar`; on the `ar` handshake go to RD_DATA.
- **RD_DATA:** `out_r` is forwarded to the owner; on the `r` handshake go to IDLE.
- **Non-owner master:** all of its `ready` and `b_valid`/`r_valid` outputs are 0; its payload outputs are don't-care and are driven with the slave values.
- **Slave channels not used in the current state:** `valid`/`ready` are 0.
- **Payload rule:** payloads are forwarded unmodified; no width conversion.

## Timing

- **Reset values:** state IDLE, `owner` 0, last-grant 0, `aw_done`/`w_done` 0, `io_busy` 0. Every `valid` and `ready` output is 0.
- **Reset mid-transaction:** return to IDLE, clear the flags, and drop any pending response. The slave shares `reset`.
- **Added latency:** exactly one cycle (the IDLE arbitration cycle) per transaction; after that, the slave's handshakes pass through with zero added latency.
- **Back-to-back:** the earliest regrant is in the cycle after the final `b`/`r` handshake, which is the IDLE cycle. Minimum period is therefore 1 + slave latency.
- **No combinational paths** from `out_*_ready` to `out_*_valid`. `inN_*_ready` depends combinationally only on `out_*_ready`, state and `owner`.
- **AXI rule:** a master's `valid` must stay high until its handshake; the arbiter never drops a forwarded `valid` mid-handshake.

## Test plan

- **Reset:** hold `reset` for 10 cycles with both masters requesting → all `valid`/`ready` outputs are 0 and `io_busy` is 0; the first grant happens in the cycle after reset deasserts.
- **Simultaneous reads:** in0 reads 0x100 and in1 reads 0x6000 in the same cycle, with the slave returning 0xAAAA0001 and 0xBBBB0002 → in1 is served first and receives 0xBBBB0002 on its `r` only; then in0 receives 0xAAAA0001; in0 never sees `r_valid` during in1's read.
- **Split write handshake:** in1 writes 0x00000001 to 0x6000 with strb 0xF; the slave accepts W one cycle before AW → exactly one `out_w` and one `out_aw` handshake; `b` (resp 0) goes only to in1; state returns to IDLE.
- **Write beats read in one master:** in1 asserts `ar` (0x40) and `aw`/`w` (0x44, 0x12345678) together → the write completes first; the read follows after the next IDLE cycle.
- **Fairness:** both masters issue reads continuously for 20 transactions → grants strictly alternate in1, in0, in1, …, 10 each.
- **Reset during RD_DATA:** assert `reset` for 1 cycle before `r_valid` → the arbiter is in IDLE with `io_busy` 0 after reset, and no `r_valid` reaches either master from the aborted read.

Source files
------------

// File: rtl/axi4lite_mem_arbiter.sv
// Two-master / one-slave AXI4-Lite arbiter. One whole transaction (read or
// write) is granted at a time in round-robin order; the owner's channels are
// forwarded to the slave and responses return only to the owner.
// Handshake rule on every channel: a transfer happens in a cycle where both
// valid and ready are high; valid never depends combinationally on ready.
module axi4lite_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  // master 0 (iBus)
  input  logic                io_in0_aw_valid,
  output logic                io_in0_aw_ready,
  input  logic [ADDR_W-1:0]   io_in0_aw_bits_addr,
  input  logic [2:0]          io_in0_aw_bits_prot,
  input  logic [3:0]          io_in0_aw_bits_cache,
  input  logic                io_in0_w_valid,
  output logic                io_in0_w_ready,
  input  logic [DATA_W-1:0]   io_in0_w_bits_data,
  input  logic [DATA_W/8-1:0] io_in0_w_bits_strb,
  output logic                io_in0_b_valid,
  input  logic                io_in0_b_ready,
  output logic [1:0]          io_in0_b_bits_resp,
  input  logic                io_in0_ar_valid,
  output logic                io_in0_ar_ready,
  input  logic [ADDR_W-1:0]   io_in0_ar_bits_addr,
  input  logic [2:0]          io_in0_ar_bits_prot,
  input  logic [3:0]          io_in0_ar_bits_cache,
  output logic                io_in0_r_valid,
  input  logic                io_in0_r_ready,
  output logic [1:0]          io_in0_r_bits_resp,
  output logic [DATA_W-1:0]   io_in0_r_bits_data,
  // master 1 (dBus)
  input  logic                io_in1_aw_valid,
  output logic                io_in1_aw_ready,
  input  logic [ADDR_W-1:0]   io_in1_aw_bits_addr,
  input  logic [2:0]          io_in1_aw_bits_prot,
  input  logic [3:0]          io_in1_aw_bits_cache,
  input  logic                io_in1_w_valid,
  output logic                io_in1_w_ready,
  input  logic [DATA_W-1:0]   io_in1_w_bits_data,
  input  logic [DATA_W/8-1:0] io_in1_w_bits_strb,
  output logic                io_in1_b_valid,
  input  logic                io_in1_b_ready,
  output logic [1:0]          io_in1_b_bits_resp,
  input  logic                io_in1_ar_valid,
  output logic                io_in1_ar_ready,
  input  logic [ADDR_W-1:0]   io_in1_ar_bits_addr,
  input  logic [2:0]          io_in1_ar_bits_prot,
  input  logic [3:0]          io_in1_ar_bits_cache,
  output logic                io_in1_r_valid,
  input  logic                io_in1_r_ready,
  output logic [1:0]          io_in1_r_bits_resp,
  output logic [DATA_W-1:0]   io_in1_r_bits_data,
  // slave side
  output logic                io_out_aw_valid,
  input  logic                io_out_aw_ready,
  output logic [ADDR_W-1:0]   io_out_aw_bits_addr,
  output logic [2:0]          io_out_aw_bits_prot,
  output logic [3:0]          io_out_aw_bits_cache,
  output logic                io_out_w_valid,
  input  logic                io_out_w_ready,
  output logic [DATA_W-1:0]   io_out_w_bits_data,
  output logic [DATA_W/8-1:0] io_out_w_bits_strb,
  input  logic                io_out_b_valid,
  output logic                io_out_b_ready,
  input  logic [1:0]          io_out_b_bits_resp,
  output logic                io_out_ar_valid,
  input  logic                io_out_ar_ready,
  output logic [ADDR_W-1:0]   io_out_ar_bits_addr,
  output logic [2:0]          io_out_ar_bits_prot,
  output logic [3:0]          io_out_ar_bits_cache,
  input  logic                io_out_r_valid,
  output logic                io_out_r_ready,
  input  logic [1:0]          io_out_r_bits_resp,
  input  logic [DATA_W-1:0]   io_out_r_bits_data,
  // status
  output logic                io_owner,
  output logic                io_busy,
  output logic [2:0]          io_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  state_t r_state;
  logic   r_owner;
  logic   r_last;
  logic   r_aw_done;
  logic   r_w_done;
  logic   r_busy;

  // Request decode and round-robin pick (only meaningful in IDLE).
  logic w_req_wr0, w_req_wr1, w_req0, w_req1, w_grant, w_grant_wr;
  assign w_req_wr0  = io_in0_aw_valid & io_in0_w_valid;
  assign w_req_wr1  = io_in1_aw_valid & io_in1_w_valid;
  assign w_req0     = w_req_wr0 | io_in0_ar_valid;
  assign w_req1     = w_req_wr1 | io_in1_ar_valid;
  assign w_grant    = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_grant_wr = w_grant ? w_req_wr1 : w_req_wr0;

  // Owner-selected master signals.
  logic w_own_aw_valid, w_own_w_valid, w_own_ar_valid, w_own_b_ready, w_own_r_ready;
  assign w_own_aw_valid = r_owner ? io_in1_aw_valid : io_in0_aw_valid;
  assign w_own_w_valid  = r_owner ? io_in1_w_valid  : io_in0_w_valid;
  assign w_own_ar_valid = r_owner ? io_in1_ar_valid : io_in0_ar_valid;
  assign w_own_b_ready  = r_owner ? io_in1_b_ready  : io_in0_b_ready;
  assign w_own_r_ready  = r_owner ? io_in1_r_ready  : io_in0_r_ready;

  // Slave-facing channels: only the channel(s) of the current state are live.
  assign io_out_aw_valid      = (r_state == S_WR_ADDR) & ~r_aw_done & w_own_aw_valid;
  assign io_out_w_valid       = (r_state == S_WR_ADDR) & ~r_w_done & w_own_w_valid;
  assign io_out_b_ready       = (r_state == S_WR_RESP) & w_own_b_ready;
  assign io_out_ar_valid      = (r_state == S_RD_ADDR) & w_own_ar_valid;
  assign io_out_r_ready       = (r_state == S_RD_DATA) & w_own_r_ready;
  assign io_out_aw_bits_addr  = r_owner ? io_in1_aw_bits_addr  : io_in0_aw_bits_addr;
  assign io_out_aw_bits_prot  = r_owner ? io_in1_aw_bits_prot  : io_in0_aw_bits_prot;
  assign io_out_aw_bits_cache = r_owner ? io_in1_aw_bits_cache : io_in0_aw_bits_cache;
  assign io_out_w_bits_data   = r_owner ? io_in1_w_bits_data   : io_in0_w_bits_data;
  assign io_out_w_bits_strb   = r_owner ? io_in1_w_bits_strb   : io_in0_w_bits_strb;
  assign io_out_ar_bits_addr  = r_owner ? io_in1_ar_bits_addr  : io_in0_ar_bits_addr;
  assign io_out_ar_bits_prot  = r_owner ? io_in1_ar_bits_prot  : io_in0_ar_bits_prot;
  assign io_out_ar_bits_cache = r_owner ? io_in1_ar_bits_cache : io_in0_ar_bits_cache;

  // Master-facing readies/valids, routed to the owner only.
  logic w_aw_rdy, w_w_rdy, w_ar_rdy, w_b_vld, w_r_vld;
  assign w_aw_rdy = (r_state == S_WR_ADDR) & ~r_aw_done & io_out_aw_ready;
  assign w_w_rdy  = (r_state == S_WR_ADDR) & ~r_w_done & io_out_w_ready;
  assign w_ar_rdy = (r_state == S_RD_ADDR) & io_out_ar_ready;
  assign w_b_vld  = (r_state == S_WR_RESP) & io_out_b_valid;
  assign w_r_vld  = (r_state == S_RD_DATA) & io_out_r_valid;

  assign io_in0_aw_ready = w_aw_rdy & ~r_owner;
  assign io_in1_aw_ready = w_aw_rdy & r_owner;
  assign io_in0_w_ready  = w_w_rdy & ~r_owner;
  assign io_in1_w_ready  = w_w_rdy & r_owner;
  assign io_in0_ar_ready = w_ar_rdy & ~r_owner;
  assign io_in1_ar_ready = w_ar_rdy & r_owner;
  assign io_in0_b_valid  = w_b_vld & ~r_owner;
  assign io_in1_b_valid  = w_b_vld & r_owner;
  assign io_in0_r_valid  = w_r_vld & ~r_owner;
  assign io_in1_r_valid  = w_r_vld & r_owner;

  // Response payloads go to both masters; only the owner sees a valid.
  assign io_in0_b_bits_resp = io_out_b_bits_resp;
  assign io_in1_b_bits_resp = io_out_b_bits_resp;
  assign io_in0_r_bits_resp = io_out_r_bits_resp;
  assign io_in1_r_bits_resp = io_out_r_bits_resp;
  assign io_in0_r_bits_data = io_out_r_bits_data;
  assign io_in1_r_bits_data = io_out_r_bits_data;

  // Slave-side handshakes.
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  assign w_aw_hs = io_out_aw_valid & io_out_aw_ready;
  assign w_w_hs  = io_out_w_valid & io_out_w_ready;
  assign w_b_hs  = io_out_b_valid & io_out_b_ready;
  assign w_ar_hs = io_out_ar_valid & io_out_ar_ready;
  assign w_r_hs  = io_out_r_valid & io_out_r_ready;

  assign io_owner     = r_owner;
  assign io_busy      = r_busy;
  assign io_dbg_state = r_state;

  // Transaction FSM: arbitrate in IDLE, then track one transaction to its response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_owner   <= w_grant;
            r_last    <= w_grant;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= w_grant_wr ? S_WR_ADDR : S_RD_ADDR;
          end
        end
        S_WR_ADDR: begin
          // A handshake completing this cycle counts toward leaving WR_ADDR.
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_state   <= S_WR_RESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (w_b_hs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RD_ADDR: begin
          if (w_ar_hs) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (w_r_hs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_mem_arbiter.sv
// Bench for axi4lite_mem_arbiter: two master driver tasks, a behavioural
// slave, and a scoreboard monitor checking slave-side request order and the
// responses delivered to each master.
module tb_axi4lite_mem_arbiter;

  localparam int BUDGET = 200;
  localparam int R_LAT  = 2;

  logic clock, reset;

  logic        io_in0_aw_valid, io_in0_aw_ready;
  logic [31:0] io_in0_aw_bits_addr;
  logic [2:0]  io_in0_aw_bits_prot;
  logic [3:0]  io_in0_aw_bits_cache;
  logic        io_in0_w_valid, io_in0_w_ready;
  logic [31:0] io_in0_w_bits_data;
  logic [3:0]  io_in0_w_bits_strb;
  logic        io_in0_b_valid, io_in0_b_ready;
  logic [1:0]  io_in0_b_bits_resp;
  logic        io_in0_ar_valid, io_in0_ar_ready;
  logic [31:0] io_in0_ar_bits_addr;
  logic [2:0]  io_in0_ar_bits_prot;
  logic [3:0]  io_in0_ar_bits_cache;
  logic        io_in0_r_valid, io_in0_r_ready;
  logic [1:0]  io_in0_r_bits_resp;
  logic [31:0] io_in0_r_bits_data;

  logic        io_in1_aw_valid, io_in1_aw_ready;
  logic [31:0] io_in1_aw_bits_addr;
  logic [2:0]  io_in1_aw_bits_prot;
  logic [3:0]  io_in1_aw_bits_cache;
  logic        io_in1_w_valid, io_in1_w_ready;
  logic [31:0] io_in1_w_bits_data;
  logic [3:0]  io_in1_w_bits_strb;
  logic        io_in1_b_valid, io_in1_b_ready;
  logic [1:0]  io_in1_b_bits_resp;
  logic        io_in1_ar_valid, io_in1_ar_ready;
  logic [31:0] io_in1_ar_bits_addr;
  logic [2:0]  io_in1_ar_bits_prot;
  logic [3:0]  io_in1_ar_bits_cache;
  logic        io_in1_r_valid, io_in1_r_ready;
  logic [1:0]  io_in1_r_bits_resp;
  logic [31:0] io_in1_r_bits_data;

  logic        io_out_aw_valid, io_out_aw_ready;
  logic [31:0] io_out_aw_bits_addr;
  logic [2:0]  io_out_aw_bits_prot;
  logic [3:0]  io_out_aw_bits_cache;
  logic        io_out_w_valid, io_out_w_ready;
  logic [31:0] io_out_w_bits_data;
  logic [3:0]  io_out_w_bits_strb;
  logic        io_out_b_valid, io_out_b_ready;
  logic [1:0]  io_out_b_bits_resp;
  logic        io_out_ar_valid, io_out_ar_ready;
  logic [31:0] io_out_ar_bits_addr;
  logic [2:0]  io_out_ar_bits_prot;
  logic [3:0]  io_out_ar_bits_cache;
  logic        io_out_r_valid, io_out_r_ready;
  logic [1:0]  io_out_r_bits_resp;
  logic [31:0] io_out_r_bits_data;

  logic        io_owner, io_busy;
  logic [2:0]  io_dbg_state;

  axi4lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .io_in0_aw_valid(io_in0_aw_valid), .io_in0_aw_ready(io_in0_aw_ready),
    .io_in0_aw_bits_addr(io_in0_aw_bits_addr), .io_in0_aw_bits_prot(io_in0_aw_bits_prot),
    .io_in0_aw_bits_cache(io_in0_aw_bits_cache),
    .io_in0_w_valid(io_in0_w_valid), .io_in0_w_ready(io_in0_w_ready),
    .io_in0_w_bits_data(io_in0_w_bits_data), .io_in0_w_bits_strb(io_in0_w_bits_strb),
    .io_in0_b_valid(io_in0_b_valid), .io_in0_b_ready(io_in0_b_ready),
    .io_in0_b_bits_resp(io_in0_b_bits_resp),
    .io_in0_ar_valid(io_in0_ar_valid), .io_in0_ar_ready(io_in0_ar_ready),
    .io_in0_ar_bits_addr(io_in0_ar_bits_addr), .io_in0_ar_bits_prot(io_in0_ar_bits_prot),
    .io_in0_ar_bits_cache(io_in0_ar_bits_cache),
    .io_in0_r_valid(io_in0_r_valid), .io_in0_r_ready(io_in0_r_ready),
    .io_in0_r_bits_resp(io_in0_r_bits_resp), .io_in0_r_bits_data(io_in0_r_bits_data),
    .io_in1_aw_valid(io_in1_aw_valid), .io_in1_aw_ready(io_in1_aw_ready),
    .io_in1_aw_bits_addr(io_in1_aw_bits_addr), .io_in1_aw_bits_prot(io_in1_aw_bits_prot),
    .io_in1_aw_bits_cache(io_in1_aw_bits_cache),
    .io_in1_w_valid(io_in1_w_valid), .io_in1_w_ready(io_in1_w_ready),
    .io_in1_w_bits_data(io_in1_w_bits_data), .io_in1_w_bits_strb(io_in1_w_bits_strb),
    .io_in1_b_valid(io_in1_b_valid), .io_in1_b_ready(io_in1_b_ready),
    .io_in1_b_bits_resp(io_in1_b_bits_resp),
    .io_in1_ar_valid(io_in1_ar_valid), .io_in1_ar_ready(io_in1_ar_ready),
    .io_in1_ar_bits_addr(io_in1_ar_bits_addr), .io_in1_ar_bits_prot(io_in1_ar_bits_prot),
    .io_in1_ar_bits_cache(io_in1_ar_bits_cache),
    .io_in1_r_valid(io_in1_r_valid), .io_in1_r_ready(io_in1_r_ready),
    .io_in1_r_bits_resp(io_in1_r_bits_resp), .io_in1_r_bits_data(io_in1_r_bits_data),
    .io_out_aw_valid(io_out_aw_valid), .io_out_aw_ready(io_out_aw_ready),
    .io_out_aw_bits_addr(io_out_aw_bits_addr), .io_out_aw_bits_prot(io_out_aw_bits_prot),
    .io_out_aw_bits_cache(io_out_aw_bits_cache),
    .io_out_w_valid(io_out_w_valid), .io_out_w_ready(io_out_w_ready),
    .io_out_w_bits_data(io_out_w_bits_data), .io_out_w_bits_strb(io_out_w_bits_strb),
    .io_out_b_valid(io_out_b_valid), .io_out_b_ready(io_out_b_ready),
    .io_out_b_bits_resp(io_out_b_bits_resp),
    .io_out_ar_valid(io_out_ar_valid), .io_out_ar_ready(io_out_ar_ready),
    .io_out_ar_bits_addr(io_out_ar_bits_addr), .io_out_ar_bits_prot(io_out_ar_bits_prot),
    .io_out_ar_bits_cache(io_out_ar_bits_cache),
    .io_out_r_valid(io_out_r_valid), .io_out_r_ready(io_out_r_ready),
    .io_out_r_bits_resp(io_out_r_bits_resp), .io_out_r_bits_data(io_out_r_bits_data),
    .io_owner(io_owner), .io_busy(io_busy), .io_dbg_state(io_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int n_aw     = 0;
  int n_w      = 0;

  logic [31:0] exp_r0_q[$];
  logic [31:0] exp_r1_q[$];
  logic [1:0]  exp_b0_q[$];
  logic [1:0]  exp_b1_q[$];
  logic [33:0] exp_addr_q[$];   // {is_write, owner, addr} in slave-arrival order
  logic [35:0] exp_w_q[$];      // {data, strb}

  logic [31:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected_event required=none", name);
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hD000, a[15:0]};
  endfunction

  // ---------------- behavioural slave ----------------
  initial begin
    logic        rst, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic        rd_pend, aw_got, w_got;
    logic [31:0] ar_a, aw_a, w_d, rd_a, wr_a, wr_d;
    int          cnt;
    io_out_ar_ready = 1'b1; io_out_r_valid = 1'b0; io_out_r_bits_data = '0;
    io_out_r_bits_resp = 2'b00; io_out_aw_ready = 1'b0; io_out_w_ready = 1'b1;
    io_out_b_valid = 1'b0; io_out_b_bits_resp = 2'b00;
    rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; cnt = 0;
    rd_a = '0; wr_a = '0; wr_d = '0;
    forever begin
      @(negedge clock);
      rst   = reset;
      ar_hs = io_out_ar_valid && io_out_ar_ready;
      r_hs  = io_out_r_valid && io_out_r_ready;
      aw_hs = io_out_aw_valid && io_out_aw_ready;
      w_hs  = io_out_w_valid && io_out_w_ready;
      b_hs  = io_out_b_valid && io_out_b_ready;
      ar_a  = io_out_ar_bits_addr;
      aw_a  = io_out_aw_bits_addr;
      w_d   = io_out_w_bits_data;
      @(posedge clock);
      #1;
      if (rst) begin
        io_out_ar_ready = 1'b1; io_out_r_valid = 1'b0;
        io_out_aw_ready = 1'b0; io_out_w_ready = 1'b1; io_out_b_valid = 1'b0;
        rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; cnt = 0;
      end else begin
        if (r_hs) begin io_out_r_valid = 1'b0; io_out_ar_ready = 1'b1; end
        if (ar_hs) begin
          rd_pend = 1'b1; rd_a = ar_a; cnt = R_LAT; io_out_ar_ready = 1'b0;
        end else if (rd_pend) begin
          if (cnt > 0) cnt--;
          if (cnt == 0) begin
            io_out_r_valid = 1'b1; io_out_r_bits_data = rd_val(rd_a); rd_pend = 1'b0;
          end
        end
        // W is always taken before AW so the address/data split is exercised.
        if (b_hs) begin io_out_b_valid = 1'b0; io_out_w_ready = 1'b1; end
        if (w_hs) begin w_got = 1'b1; wr_d = w_d; io_out_w_ready = 1'b0; io_out_aw_ready = 1'b1; end
        if (aw_hs) begin aw_got = 1'b1; wr_a = aw_a; end
        if (w_got && aw_got) begin
          mem[wr_a] = wr_d;
          io_out_b_valid = 1'b1; io_out_aw_ready = 1'b0;
          w_got = 1'b0; aw_got = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (io_in0_r_valid && io_in0_r_ready) begin
        if (exp_r0_q.size() == 0) unexpected("in0_r_valid");
        else check("in0_r_data", 64'(io_in0_r_bits_data), 64'(exp_r0_q.pop_front()));
      end
      if (io_in1_r_valid && io_in1_r_ready) begin
        if (exp_r1_q.size() == 0) unexpected("in1_r_valid");
        else check("in1_r_data", 64'(io_in1_r_bits_data), 64'(exp_r1_q.pop_front()));
      end
      if (io_in0_b_valid && io_in0_b_ready) begin
        if (exp_b0_q.size() == 0) unexpected("in0_b_valid");
        else check("in0_b_resp", 64'(io_in0_b_bits_resp), 64'(exp_b0_q.pop_front()));
      end
      if (io_in1_b_valid && io_in1_b_ready) begin
        if (exp_b1_q.size() == 0) unexpected("in1_b_valid");
        else check("in1_b_resp", 64'(io_in1_b_bits_resp), 64'(exp_b1_q.pop_front()));
      end
      if (io_out_ar_valid && io_out_ar_ready) begin
        if (exp_addr_q.size() == 0) unexpected("out_ar");
        else check("out_ar_order", 64'({1'b0, io_owner, io_out_ar_bits_addr}), 64'(exp_addr_q.pop_front()));
      end
      if (io_out_aw_valid && io_out_aw_ready) begin
        n_aw++;
        if (exp_addr_q.size() == 0) unexpected("out_aw");
        else check("out_aw_order", 64'({1'b1, io_owner, io_out_aw_bits_addr}), 64'(exp_addr_q.pop_front()));
      end
      if (io_out_w_valid && io_out_w_ready) begin
        n_w++;
        if (exp_w_q.size() == 0) unexpected("out_w");
        else check("out_w_data", 64'({io_out_w_bits_data, io_out_w_bits_strb}), 64'(exp_w_q.pop_front()));
      end
    end
  end

  // ---------------- master driver tasks ----------------
  task automatic master_read(input int m, input logic [31:0] addr, input logic [31:0] exp_data);
    bit got;
    if (m == 0) exp_r0_q.push_back(exp_data); else exp_r1_q.push_back(exp_data);
    if (m == 0) begin io_in0_ar_bits_addr = addr; io_in0_ar_valid = 1'b1; end
    else        begin io_in1_ar_bits_addr = addr; io_in1_ar_valid = 1'b1; end
    got = 1'b0;
    for (int c = 0; c < BUDGET && !got; c++) begin
      @(negedge clock);
      got = (m == 0) ? io_in0_ar_ready : io_in1_ar_ready;
    end
    if (!got) unexpected("ar_ready_timeout");
    @(posedge clock); #1;
    if (m == 0) io_in0_ar_valid = 1'b0; else io_in1_ar_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < BUDGET && !got; c++) begin
      @(negedge clock);
      got = (m == 0) ? io_in0_r_valid : io_in1_r_valid;
    end
    if (!got) unexpected("r_valid_timeout");
    @(posedge clock); #1;
  endtask

  task automatic master_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    bit aw_d, w_d, aw_hs, w_hs, got;
    exp_w_q.push_back({data, strb});
    if (m == 0) exp_b0_q.push_back(2'b00); else exp_b1_q.push_back(2'b00);
    if (m == 0) begin
      io_in0_aw_bits_addr = addr; io_in0_w_bits_data = data; io_in0_w_bits_strb = strb;
      io_in0_aw_valid = 1'b1; io_in0_w_valid = 1'b1;
    end else begin
      io_in1_aw_bits_addr = addr; io_in1_w_bits_data = data; io_in1_w_bits_strb = strb;
      io_in1_aw_valid = 1'b1; io_in1_w_valid = 1'b1;
    end
    aw_d = 1'b0; w_d = 1'b0;
    for (int c = 0; c < BUDGET && !(aw_d && w_d); c++) begin
      @(negedge clock);
      aw_hs = !aw_d && ((m == 0) ? io_in0_aw_ready : io_in1_aw_ready);
      w_hs  = !w_d && ((m == 0) ? io_in0_w_ready : io_in1_w_ready);
      @(posedge clock); #1;
      if (aw_hs) begin aw_d = 1'b1; if (m == 0) io_in0_aw_valid = 1'b0; else io_in1_aw_valid = 1'b0; end
      if (w_hs)  begin w_d = 1'b1;  if (m == 0) io_in0_w_valid = 1'b0;  else io_in1_w_valid = 1'b0; end
    end
    if (!(aw_d && w_d)) unexpected("aw_w_timeout");
    got = 1'b0;
    for (int c = 0; c < BUDGET && !got; c++) begin
      @(negedge clock);
      got = (m == 0) ? io_in0_b_valid : io_in1_b_valid;
    end
    if (!got) unexpected("b_valid_timeout");
    @(posedge clock); #1;
  endtask

  function automatic logic [15:0] vr_bits();
    return {io_in0_aw_ready, io_in0_w_ready, io_in0_b_valid, io_in0_ar_ready, io_in0_r_valid,
            io_in1_aw_ready, io_in1_w_ready, io_in1_b_valid, io_in1_ar_ready, io_in1_r_valid,
            io_out_aw_valid, io_out_w_valid, io_out_b_ready, io_out_ar_valid, io_out_r_ready,
            io_busy};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int aw0, w0;
    reset = 1'b1;
    io_in0_aw_valid = 0; io_in0_aw_bits_addr = '0; io_in0_aw_bits_prot = '0; io_in0_aw_bits_cache = '0;
    io_in0_w_valid = 0; io_in0_w_bits_data = '0; io_in0_w_bits_strb = '0; io_in0_b_ready = 1;
    io_in0_ar_valid = 0; io_in0_ar_bits_addr = '0; io_in0_ar_bits_prot = '0; io_in0_ar_bits_cache = '0;
    io_in0_r_ready = 1;
    io_in1_aw_valid = 0; io_in1_aw_bits_addr = '0; io_in1_aw_bits_prot = '0; io_in1_aw_bits_cache = '0;
    io_in1_w_valid = 0; io_in1_w_bits_data = '0; io_in1_w_bits_strb = '0; io_in1_b_ready = 1;
    io_in1_ar_valid = 0; io_in1_ar_bits_addr = '0; io_in1_ar_bits_prot = '0; io_in1_ar_bits_cache = '0;
    io_in1_r_ready = 1;
    mem[32'h0000_0100] = 32'hAAAA_0001;
    mem[32'h0000_6000] = 32'hBBBB_0002;
    mem[32'h0000_0040] = 32'hCAFE_0040;

    // Reset held with both masters requesting, then simultaneous reads: in1 wins the tie.
    exp_addr_q.push_back({1'b0, 1'b1, 32'h0000_6000});
    exp_addr_q.push_back({1'b0, 1'b0, 32'h0000_0100});
    fork
      master_read(0, 32'h0000_0100, 32'hAAAA_0001);
      master_read(1, 32'h0000_6000, 32'hBBBB_0002);
      begin
        @(posedge clock);
        for (int i = 0; i < 10; i++) begin
          @(negedge clock);
          check("reset_valid_ready", 64'(vr_bits()), 64'd0);
          check("reset_state_owner", 64'({io_dbg_state, io_owner}), 64'd0);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle_after_reset_busy", 64'(io_busy), 64'd0);
        @(negedge clock);
        check("first_grant_busy_owner", 64'({io_busy, io_owner}), 64'b11);
      end
    join

    // Split write: slave takes W one cycle before AW.
    aw0 = n_aw; w0 = n_w;
    exp_addr_q.push_back({1'b1, 1'b1, 32'h0000_6000});
    master_write(1, 32'h0000_6000, 32'h0000_0001, 4'hF);
    @(negedge clock);
    check("split_aw_count", 64'(n_aw - aw0), 64'd1);
    check("split_w_count", 64'(n_w - w0), 64'd1);
    check("split_idle", 64'({io_busy, io_dbg_state}), 64'd0);

    // Write beats read within the same master.
    exp_addr_q.push_back({1'b1, 1'b1, 32'h0000_0044});
    exp_addr_q.push_back({1'b0, 1'b1, 32'h0000_0040});
    fork
      master_write(1, 32'h0000_0044, 32'h1234_5678, 4'hF);
      master_read(1, 32'h0000_0040, 32'hCAFE_0040);
    join
    @(negedge clock);
    check("wbr_mem_written", 64'(mem[32'h0000_0044]), 64'h1234_5678);

    // Reset during RD_DATA: the read response must never appear.
    @(posedge clock); #1;
    exp_addr_q.push_back({1'b0, 1'b0, 32'h0000_0300});
    io_in0_ar_bits_addr = 32'h0000_0300; io_in0_ar_valid = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < BUDGET && !got; c++) begin
        @(negedge clock);
        got = io_in0_ar_ready;
      end
      if (!got) unexpected("abort_ar_timeout");
    end
    @(posedge clock); #1;
    io_in0_ar_valid = 1'b0;
    @(negedge clock);
    check("abort_in_rd_data", 64'(io_dbg_state), 64'd4);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_idle", 64'({io_busy, io_dbg_state}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("abort_no_r_valid", 64'({io_in0_r_valid, io_in1_r_valid}), 64'd0);
    end

    // Fairness: continuous reads from both masters alternate in1, in0, ...
    for (int k = 0; k < 10; k++) begin
      exp_addr_q.push_back({1'b0, 1'b1, 32'h0000_7000 + 32'(4 * k)});
      exp_addr_q.push_back({1'b0, 1'b0, 32'h0000_0200 + 32'(4 * k)});
    end
    fork
      for (int k = 0; k < 10; k++)
        master_read(0, 32'h0000_0200 + 32'(4 * k), {16'hD000, 16'h0200 + 16'(4 * k)});
      for (int k = 0; k < 10; k++)
        master_read(1, 32'h0000_7000 + 32'(4 * k), {16'hD000, 16'h7000 + 16'(4 * k)});
    join

    repeat (4) @(negedge clock);
    check("end_idle", 64'({io_busy, io_dbg_state}), 64'd0);
    check("left_addr", 64'(exp_addr_q.size()), 64'd0);
    check("left_r0", 64'(exp_r0_q.size()), 64'd0);
    check("left_r1", 64'(exp_r1_q.size()), 64'd0);
    check("left_b1", 64'(exp_b1_q.size()), 64'd0);
    check("left_w", 64'(exp_w_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
